// File: rtl/change_pkg.sv
// Shared types and defaults for the change dispenser.
// Count width covers ceil(2^16/5) = 13108 transfers for the default configuration.
package change_pkg;

    localparam int STEP_DEF = 5;
    localparam int CNT_W    = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/change_dispenser_if.sv
// Job request, unit handshake and status bundle between a controller (master) and the dispenser (slave).
// out_valid/out_ready form the per-unit handshake; everything else is level status.
interface change_dispenser_if #(
    parameter int W = 16
) ();
    import change_pkg::*;

    logic             start;
    logic [W-1:0]     amount;
    logic             abort;
    logic             out_ready;
    logic             out_valid;
    logic             busy;
    logic             done;
    logic             residue_err;
    logic [W-1:0]     remain;
    logic [CNT_W-1:0] count;

    modport master (
        output start, amount, abort, out_ready,
        input  out_valid, busy, done, residue_err, remain, count
    );

    modport slave (
        input  start, amount, abort, out_ready,
        output out_valid, busy, done, residue_err, remain, count
    );

endinterface

// File: rtl/change_dispenser.sv
// Dispenses a latched amount in STEP-sized units, one per accepted out_valid/out_ready handshake.
// First unit is offered one cycle after start; out_valid depends on registers only, so it holds under backpressure.
module change_dispenser
    import change_pkg::*;
#(
    parameter int STEP = STEP_DEF,
    parameter int W    = 16
) (
    input  logic         clk,
    input  logic         rst,
    change_dispenser_if.slave dsp
);

    localparam logic [W-1:0] STEP_W = W'(STEP);

    state_e           state_q;
    logic [W-1:0]     remain_q;
    logic [W-1:0]     remain_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             residue_q;
    logic             has_unit;

    // Single comparator, subtractor and incrementer shared by the whole job.
    assign has_unit = (remain_q >= STEP_W);
    assign remain_d = remain_q - STEP_W;
    assign count_d  = count_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            remain_q  <= '0;
            count_q   <= '0;
            residue_q <= 1'b0;
        end else if (dsp.abort) begin
            // Cancel keeps the partial balance and count visible for inspection.
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dsp.start) begin
                        remain_q  <= dsp.amount;
                        count_q   <= '0;
                        residue_q <= 1'b0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    if (!has_unit) begin
                        residue_q <= (remain_q != '0);
                        state_q   <= DONE;
                    end else if (dsp.out_ready) begin
                        remain_q <= remain_d;
                        count_q  <= count_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dsp.out_valid   = (state_q == RUN) && has_unit;
    assign dsp.busy        = (state_q != IDLE);
    assign dsp.done        = (state_q == DONE);
    assign dsp.residue_err = residue_q;
    assign dsp.remain      = remain_q;
    assign dsp.count       = count_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized and directed jobs for change_dispenser, checked against per-job arithmetic expectations
// (units = amount / STEP, residue = amount % STEP) rather than a state-machine replica.
module tb_change_dispenser;

    localparam int STEP = 5;
    localparam int W    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    change_dispenser_if #(.W(W)) dif ();

    change_dispenser #(
        .STEP (STEP),
        .W    (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .dsp (dif.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input bit vld, input bit bsy, input bit dn,
                              input bit res, input int rem, input int cnt);
        check({tag, "_vld"},  32'(dif.out_valid),   32'(vld));
        check({tag, "_busy"}, 32'(dif.busy),        32'(bsy));
        check({tag, "_done"}, 32'(dif.done),        32'(dn));
        check({tag, "_res"},  32'(dif.residue_err), 32'(res));
        check({tag, "_rem"},  32'(dif.remain),      32'(rem));
        check({tag, "_cnt"},  32'(dif.count),       32'(cnt));
    endtask

    // mode 0: always ready; 1: random ready plus stray starts; 2: ready pattern 0,1,0,0,1,1...
    task automatic run_job(input int a, input int mode);
        int n;
        int xf;
        int i;
        bit rdy;
        n  = a / STEP;
        xf = 0;
        i  = 0;
        dif.start  = 1'b1;
        dif.amount = 16'(a);
        @(negedge clk);
        dif.start = 1'b0;
        while (xf < n) begin
            check_outs("run", 1'b1, 1'b1, 1'b0, 1'b0, a - xf * STEP, xf);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 3) != 0) || (i > 200);
                default: rdy = (i == 1) || (i >= 4);
            endcase
            dif.out_ready = rdy;
            if (mode == 1) begin
                dif.start  = 1'($urandom_range(0, 1));
                dif.amount = 16'($urandom);
            end
            if (rdy) xf++;
            i++;
            @(negedge clk);
        end
        dif.out_ready = 1'($urandom_range(0, 1));
        dif.start     = 1'b1;
        dif.amount    = 16'($urandom);
        check_outs("tail", 1'b0, 1'b1, 1'b0, 1'b0, a % STEP, n);
        @(negedge clk);
        check_outs("done", 1'b0, 1'b1, 1'b1, (a % STEP) != 0, a % STEP, n);
        @(negedge clk);
        dif.start = 1'b0;
        check_outs("idle", 1'b0, 1'b0, 1'b0, (a % STEP) != 0, a % STEP, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        dif.start     = 1'b0;
        dif.amount    = '0;
        dif.abort     = 1'b0;
        dif.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (2) @(negedge clk);
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        check_outs("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        run_job(20, 0);
        run_job(23, 0);
        run_job(3, 0);
        run_job(0, 0);
        run_job(10, 2);

        // Abort after two transfers; abort beats a simultaneous handshake and a stray start.
        dif.start  = 1'b1;
        dif.amount = 16'd50;
        @(negedge clk);
        dif.start     = 1'b0;
        dif.out_ready = 1'b1;
        check_outs("ab_run0", 1'b1, 1'b1, 1'b0, 1'b0, 50, 0);
        repeat (2) @(negedge clk);
        check_outs("ab_run2", 1'b1, 1'b1, 1'b0, 1'b0, 40, 2);
        dif.abort  = 1'b1;
        dif.start  = 1'b1;
        dif.amount = 16'd7;
        @(negedge clk);
        dif.abort = 1'b0;
        dif.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_outs("ab_idle", 1'b0, 1'b0, 1'b0, 1'b0, 40, 2);
            @(negedge clk);
        end
        dif.abort  = 1'b1;
        dif.start  = 1'b1;
        dif.amount = 16'd7;
        @(negedge clk);
        dif.abort = 1'b0;
        dif.start = 1'b0;
        check_outs("ab_start", 1'b0, 1'b0, 1'b0, 1'b0, 40, 2);

        // Reset mid-job discards the partial result.
        dif.start  = 1'b1;
        dif.amount = 16'd100;
        @(negedge clk);
        dif.start = 1'b0;
        repeat (3) @(negedge clk);
        check_outs("pre_rst", 1'b1, 1'b1, 1'b0, 1'b0, 85, 3);
        rst = 1'b1;
        @(negedge clk);
        rst           = 1'b0;
        dif.out_ready = 1'b0;
        check_outs("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        run_job(5, 0);

        for (int j = 0; j < 30; j++) begin
            run_job(int'($urandom_range(0, 80)), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter STEP, default 5: units removed per transfer; matches the accumulator increment.
REQ-002 Parameter W, default 16: width of the amount and remain values.
REQ-003 clk  input  1  the single clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin dispensing amount; sampled only in IDLE.
REQ-006 amount  input  W  value to dispense; latched on an accepted start.
REQ-007 abort  input  1  synchronous cancel of the current job, like a clear.
REQ-008 out_ready  input  1  downstream accepts one STEP unit.
REQ-009 out_valid  output  1  one STEP unit is offered.
REQ-010 busy  output  1  job in progress (RUN or DONE).
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 residue_err  output  1  the finished job left a nonzero remainder below STEP.
REQ-013 remain  output  W  undispensed balance.
REQ-014 count  output  14  transfers completed in the current job.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE, held in a registered state variable.
REQ-016 IDLE: start=1 and abort=0 SHALL load remain<=amount, count<=0, residue_err<=0, and move to RUN on the next edge.
REQ-017 RUN: out_valid SHALL equal (remain>=STEP), decoded from registers only, with no combinational path from out_ready.
REQ-018 RUN: out_valid and out_ready both high SHALL apply remain<=remain-STEP and count<=count+1 at that edge.
REQ-019 RUN with remain<STEP SHALL go to DONE on the next edge and set residue_err<=(remain!=0).
REQ-020 DONE: done SHALL be high for exactly one cycle, then the FSM returns to IDLE.
REQ-021 out_valid, once high, SHALL stay high with remain unchanged until the handshake or an abort.
REQ-022 start SHALL be ignored in RUN and DONE.
REQ-023 abort in RUN or DONE SHALL force IDLE on the next edge; remain and count hold, done is not pulsed and residue_err is unchanged.
REQ-024 abort and start together in IDLE: abort wins and no job loads.
REQ-025 Subtraction SHALL never underflow; count SHALL never exceed ceil(2^W/STEP).
REQ-026 remain, count and residue_err SHALL hold their values in IDLE until the next accepted start.
REQ-027 Latency: amount>=STEP with out_ready=1 gives the first out_valid one cycle after start, then one transfer per cycle.

Reset
REQ-028 rst=1 SHALL, at the next edge, set state=IDLE and remain=0, count=0, out_valid=0, busy=0, done=0, residue_err=0.
REQ-029 rst SHALL take priority over abort, start and handshakes, including mid-RUN; a partial job is discarded.

Structure
REQ-030 A shared package change_pkg SHALL hold the state enum, the STEP default and the count width; the accumulator and dispenser both import it.
REQ-031 The design SHALL be a single module with no sub-module; the datapath is one subtractor, one incrementer and a comparator.

Verification
REQ-032 amount=20, out_ready=1, start at cycle 0 -> out_valid cycles 1-4, count=4, remain=0, done at cycle 6, residue_err=0.
REQ-033 amount=23 -> 4 transfers, remain=3, residue_err=1 with done.
REQ-034 amount=3 -> no out_valid, done pulse, residue_err=1; then amount=0 -> done, residue_err=0.
REQ-035 amount=10, out_ready pattern 0,1,0,0,1 -> out_valid held stable, exactly 2 transfers, remain=0.
REQ-036 amount=50, abort after 2 transfers -> IDLE next cycle, remain=40, count=2, no done; start while busy is ignored.
REQ-037 rst asserted mid-RUN -> all outputs zero next cycle; a following start with amount=5 completes normally.
